// File: rtl/axi_burst_pattern_master.sv
// AXI4 burst master: writes C_NUM_BURSTS incrementing-pattern bursts, reads them back and checks every beat.
// Optional handshake watchdog enabled by defining AXI_PATTERN_TIMEOUT_EN.
module axi_burst_pattern_master #(
    parameter int unsigned               C_ADDR_WIDTH     = 32,
    parameter int unsigned               C_DATA_WIDTH     = 32,
    parameter int unsigned               C_BURST_LEN      = 16,
    parameter int unsigned               C_NUM_BURSTS     = 4,
    parameter logic [C_ADDR_WIDTH-1:0]   C_BASE_ADDR      = 'h4000_0000,
    parameter int unsigned               C_TIMEOUT_CYCLES = 1024
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        INIT_AXI_TXN,
    output logic                        TXN_DONE,
    output logic                        ERROR,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                  M_AXI_AWLEN,
    output logic [2:0]                  M_AXI_AWSIZE,
    output logic [1:0]                  M_AXI_AWBURST,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                        M_AXI_WLAST,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int unsigned BURST_BYTES = C_BURST_LEN * (C_DATA_WIDTH / 8);
    localparam logic [C_ADDR_WIDTH-1:0] STRIDE = C_ADDR_WIDTH'(BURST_BYTES);

    if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128)) begin : g_bad_width
        $error("C_DATA_WIDTH must be 32, 64 or 128");
    end
    if (C_BURST_LEN < 1 || C_BURST_LEN > 256 || C_NUM_BURSTS < 1 || C_NUM_BURSTS > 1024
        || C_TIMEOUT_CYCLES < 1) begin : g_bad_count
        $error("C_BURST_LEN, C_NUM_BURSTS or C_TIMEOUT_CYCLES out of range");
    end
    // Stride-aligned bursts stay inside a 4 KB page only if the burst size divides 4096.
    if ((4096 % BURST_BYTES) != 0) begin : g_bad_4k
        $error("burst crosses a 4 KB boundary");
    end
    if ((64'(C_BASE_ADDR) % 64'(BURST_BYTES)) != 0) begin : g_bad_base
        $error("C_BASE_ADDR not aligned to the burst size");
    end

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t                    state, state_next;
    logic                      init_q, init_d, start;
    logic [7:0]                beat_cnt;
    logic [10:0]               burst_cnt;
    logic [31:0]               pat;
    logic [C_DATA_WIDTH-1:0]   pat_ext;
    logic [C_ADDR_WIDTH-1:0]   addr;
    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                      last_beat, last_burst, timeout, err_now;

    assign M_AXI_AWVALID = (state == WR_ADDR);
    assign M_AXI_WVALID  = (state == WR_DATA);
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign M_AXI_ARVALID = (state == RD_ADDR);
    assign M_AXI_RREADY  = (state == RD_DATA);
    assign TXN_DONE      = (state == DONE);

    assign M_AXI_AWADDR  = addr;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_AWLEN   = 8'(C_BURST_LEN - 1);
    assign M_AXI_ARLEN   = 8'(C_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(C_DATA_WIDTH / 8));
    assign M_AXI_ARSIZE  = 3'($clog2(C_DATA_WIDTH / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WDATA   = pat_ext;
    assign M_AXI_WLAST   = last_beat;

    assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs       = M_AXI_BREADY & M_AXI_BVALID;
    assign ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs       = M_AXI_RREADY & M_AXI_RVALID;
    assign last_beat  = (beat_cnt == 8'(C_BURST_LEN - 1));
    assign last_burst = (burst_cnt == 11'(C_NUM_BURSTS - 1));
    assign start      = init_q & ~init_d & ((state == IDLE) | (state == DONE));

    always_comb begin
        pat_ext       = '0;
        pat_ext[31:0] = pat;
    end

    // RLAST must match the beat counter exactly; the burst still ends on the count.
    assign err_now = timeout
                   | (b_hs & (M_AXI_BRESP != 2'b00))
                   | (r_hs & ((M_AXI_RRESP != 2'b00) | (M_AXI_RDATA != pat_ext)
                              | (M_AXI_RLAST != last_beat)));

`ifdef AXI_PATTERN_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        pending, handshake;

    assign pending   = M_AXI_AWVALID | M_AXI_WVALID | M_AXI_ARVALID | M_AXI_BREADY | M_AXI_RREADY;
    assign handshake = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign timeout   = pending & ~handshake & (wd_cnt == 32'(C_TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET || !pending || handshake) wd_cnt <= '0;
        else                                 wd_cnt <= wd_cnt + 32'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = WR_ADDR;
            WR_ADDR:    if (aw_hs) state_next = WR_DATA;
            WR_DATA:    if (w_hs && last_beat) state_next = WR_RESP;
            WR_RESP:    if (b_hs) state_next = last_burst ? RD_ADDR : WR_ADDR;
            RD_ADDR:    if (ar_hs) state_next = RD_DATA;
            RD_DATA:    if (r_hs && last_beat) state_next = last_burst ? DONE : RD_ADDR;
            default:    state_next = IDLE;
        endcase
        if (timeout) state_next = DONE;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            init_q    <= 1'b0;
            init_d    <= 1'b0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            pat       <= '0;
            addr      <= '0;
            ERROR     <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            init_d <= init_q;
            if (start) begin
                beat_cnt  <= '0;
                burst_cnt <= '0;
                pat       <= 32'd1;
                addr      <= C_BASE_ADDR;
                ERROR     <= 1'b0;
            end else begin
                if (err_now) ERROR <= 1'b1;
                if (w_hs || r_hs) begin
                    pat      <= pat + 32'd1;
                    beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
                end
                // Address and burst counters wrap to the base so the read pass replays the writes.
                if (b_hs || (r_hs && last_beat)) begin
                    if (last_burst) begin
                        burst_cnt <= '0;
                        addr      <= C_BASE_ADDR;
                    end else begin
                        burst_cnt <= burst_cnt + 11'd1;
                        addr      <= addr + STRIDE;
                    end
                end
                if (b_hs && last_burst) pat <= 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_pattern_master.sv
// Bench for axi_burst_pattern_master: reactive memory slave with fault injection and scenario table.
module tb_axi_burst_pattern_master;
    localparam int AW = 32, DW = 32, LEN = 16, NB = 4, BYTES = DW / 8;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic areset, init, txn_done, error;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi_burst_pattern_master #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_BURST_LEN(LEN), .C_NUM_BURSTS(NB),
        .C_BASE_ADDR(BASE), .C_TIMEOUT_CYCLES(1024)
    ) dut (
        .ACLK(clk), .ARESET(areset), .INIT_AXI_TXN(init), .TXN_DONE(txn_done), .ERROR(error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0, miss = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int stall_max;
        int bad_rdata_g;
        int bad_bresp_b;
        int bad_rlast_g;
        bit long_init;
        bit exp_error;
    } scen_t;

    // Slave configuration and observations
    int stall_max = 0, bad_rdata_g = 0, bad_bresp_b = -1, bad_rlast_g = 0;
    bit aw_block = 1'b0;
    logic [31:0] aw_q[$], ar_q[$], w_q[$];
    logic wl_q[$];
    int b_cnt = 0, r_g = 0, r_hs_cyc = -10;
    logic [DW-1:0] mem [logic [31:0]];

    function automatic int rnd();
        return (stall_max == 0) ? 0 : int'($urandom_range(0, unsigned'(stall_max)));
    endfunction

    initial begin
        bit aw_pend = 0, w_pend = 0, ar_pend = 0, b_pend = 0, r_pend = 0;
        int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0, w_beat = 0, r_beat = 0;
        logic [31:0] aw_hold = '0, ar_hold = '0, w_addr = '0, r_addr = '0;
        logic [DW:0] w_hold = '0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
        rvalid = 0; rresp = 0; rlast = 0; rdata = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
            end else begin
                // write response: VALID stays up until accepted
                if (b_pend) begin
                    if (b_wait > 0) begin bvalid = 0; b_wait--; end
                    else begin
                        bvalid = 1;
                        bresp = (b_cnt == bad_bresp_b) ? 2'b10 : 2'b00;
                        if (bready) begin b_pend = 0; b_cnt++; end
                    end
                end else bvalid = 0;
                // read data
                if (r_pend) begin
                    if (r_wait > 0) begin rvalid = 0; r_wait--; end
                    else begin
                        rvalid = 1; rresp = 2'b00;
                        rdata = (r_g + 1 == bad_rdata_g) ? '0 : mem[r_addr + 32'(r_beat * BYTES)];
                        rlast = (r_beat == LEN - 1) ^ (r_g + 1 == bad_rlast_g);
                        if (rready) begin
                            r_hs_cyc = cyc; r_g++; r_beat++; r_wait = rnd();
                            if (r_beat == LEN) r_pend = 0;
                        end
                    end
                end else rvalid = 0;
                // write address
                if (aw_pend && !aw_block) chk("aw_valid_held", 128'(awvalid), 128'(1));
                if (awvalid) begin
                    if (aw_pend) chk("aw_stable", 128'(awaddr), 128'(aw_hold));
                    else begin aw_hold = awaddr; aw_wait = rnd(); end
                    if (aw_block || aw_wait > 0) begin
                        awready = 0; aw_pend = 1;
                        if (aw_wait > 0) aw_wait--;
                    end else begin
                        awready = 1; aw_pend = 0; aw_q.push_back(awaddr);
                        chk("awlen", 128'(awlen), 128'(LEN - 1));
                        chk("awsize", 128'(awsize), 128'(2));
                        chk("awburst", 128'(awburst), 128'(1));
                        w_addr = awaddr; w_beat = 0;
                    end
                end else begin awready = 0; aw_pend = 0; end
                // write data
                if (w_pend) chk("w_valid_held", 128'(wvalid), 128'(1));
                if (wvalid) begin
                    if (w_pend) chk("w_stable", 128'({wlast, wdata}), 128'(w_hold));
                    else begin w_hold = {wlast, wdata}; w_wait = rnd(); end
                    if (w_wait > 0) begin wready = 0; w_pend = 1; w_wait--; end
                    else begin
                        wready = 1; w_pend = 0;
                        w_q.push_back(wdata); wl_q.push_back(wlast);
                        chk("wstrb", 128'(wstrb), 128'({(DW/8){1'b1}}));
                        mem[w_addr + 32'(w_beat * BYTES)] = wdata;
                        w_beat++;
                        if (w_beat == LEN) begin b_pend = 1; b_wait = rnd(); end
                    end
                end else begin wready = 0; w_pend = 0; end
                // read address
                if (ar_pend) chk("ar_valid_held", 128'(arvalid), 128'(1));
                if (arvalid) begin
                    if (ar_pend) chk("ar_stable", 128'(araddr), 128'(ar_hold));
                    else begin ar_hold = araddr; ar_wait = rnd(); end
                    if (ar_wait > 0) begin arready = 0; ar_pend = 1; ar_wait--; end
                    else begin
                        arready = 1; ar_pend = 0; ar_q.push_back(araddr);
                        chk("arlen", 128'(arlen), 128'(LEN - 1));
                        chk("arsize", 128'(arsize), 128'(2));
                        chk("arburst", 128'(arburst), 128'(1));
                        r_pend = 1; r_addr = araddr; r_beat = 0; r_wait = rnd();
                    end
                end else begin arready = 0; ar_pend = 0; end
            end
        end
    end

    task automatic clear_obs();
        aw_q.delete(); ar_q.delete(); w_q.delete(); wl_q.delete();
        b_cnt = 0; r_g = 0; r_hs_cyc = -10;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 areset = 1;
        @(posedge clk); #1 areset = 0;
    endtask

    task automatic run_scen(input int id, input scen_t s);
        int n = 0, done_cyc = -1;
        bit seen_low = 0;
        stall_max = s.stall_max; bad_rdata_g = s.bad_rdata_g;
        bad_bresp_b = s.bad_bresp_b; bad_rlast_g = s.bad_rlast_g;
        clear_obs();
        @(negedge clk); init = 1;
        while (n < 20000) begin
            @(negedge clk); n++;
            if (s.long_init) begin
                if (n == 100) init = 0;
                if (n == 150) init = 1;
                if (n == 151) init = 0;
            end else if (n == 1) init = 0;
            if (!txn_done) seen_low = 1;
            else if (seen_low) begin done_cyc = cyc; break; end
        end
        init = 0;
        chk($sformatf("s%0d_done_reached", id), 128'(done_cyc >= 0), 128'(1));
        chk($sformatf("s%0d_done_latency", id), 128'(done_cyc), 128'(r_hs_cyc + 1));
        chk($sformatf("s%0d_error", id), 128'(error), 128'(s.exp_error));
        chk($sformatf("s%0d_aw_count", id), 128'(aw_q.size()), 128'(NB));
        chk($sformatf("s%0d_ar_count", id), 128'(ar_q.size()), 128'(NB));
        chk($sformatf("s%0d_w_count", id), 128'(w_q.size()), 128'(NB * LEN));
        chk($sformatf("s%0d_r_count", id), 128'(r_g), 128'(NB * LEN));
        for (int b = 0; b < NB; b++) begin
            if (b < aw_q.size())
                chk($sformatf("s%0d_aw_addr%0d", id, b), 128'(aw_q[b]), 128'(BASE + 32'(b * LEN * BYTES)));
            if (b < ar_q.size())
                chk($sformatf("s%0d_ar_addr%0d", id, b), 128'(ar_q[b]), 128'(BASE + 32'(b * LEN * BYTES)));
        end
        for (int g = 1; g <= NB * LEN && g <= w_q.size(); g++) begin
            chk($sformatf("s%0d_wdata_g%0d", id, g), 128'(w_q[g-1]), 128'(g));
            chk($sformatf("s%0d_wlast_g%0d", id, g), 128'(wl_q[g-1]), 128'((g % LEN) == 0));
        end
        repeat (20) @(negedge clk);
        chk($sformatf("s%0d_done_held", id), 128'(txn_done), 128'(1));
        chk($sformatf("s%0d_single_run", id), 128'(aw_q.size()), 128'(NB));
        chk($sformatf("s%0d_error_held", id), 128'(error), 128'(s.exp_error));
        if (done_cyc < 0) pulse_reset();
    endtask

    initial begin
        scen_t tbl[7];
        int n;
        areset = 1; init = 0;
        // stall, bad rdata g, bad bresp burst, bad rlast g, long init, expected ERROR
        tbl[0] = '{0, 0,  -1, 0,  1'b0, 1'b0};
        tbl[1] = '{0, 38, -1, 0,  1'b0, 1'b1};
        tbl[2] = '{0, 0,  1,  0,  1'b0, 1'b1};
        tbl[3] = '{7, 0,  -1, 0,  1'b1, 1'b0};
        tbl[4] = '{0, 0,  -1, 16, 1'b0, 1'b1};
        tbl[5] = '{2, 0,  -1, 5,  1'b0, 1'b1};
        tbl[6] = '{3, 0,  -1, 0,  1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", 128'(awvalid), 128'(0));
        chk("rst_wvalid", 128'(wvalid), 128'(0));
        chk("rst_arvalid", 128'(arvalid), 128'(0));
        chk("rst_bready", 128'(bready), 128'(0));
        chk("rst_rready", 128'(rready), 128'(0));
        chk("rst_txn_done", 128'(txn_done), 128'(0));
        chk("rst_error", 128'(error), 128'(0));
        areset = 0;

        for (int i = 0; i < 7; i++) run_scen(i, tbl[i]);

        // reset in the middle of the first write burst
        stall_max = 0; bad_rdata_g = 0; bad_bresp_b = -1; bad_rlast_g = 0;
        clear_obs();
        @(negedge clk); init = 1;
        @(negedge clk); init = 0;
        n = 0;
        while (w_q.size() < 7 && n < 1000) begin @(posedge clk); n++; end
        chk("midrst_reached_beat7", 128'(w_q.size() >= 7), 128'(1));
        #1 areset = 1;
        @(posedge clk); #1;
        chk("midrst_awvalid", 128'(awvalid), 128'(0));
        chk("midrst_wvalid", 128'(wvalid), 128'(0));
        chk("midrst_arvalid", 128'(arvalid), 128'(0));
        chk("midrst_bready", 128'(bready), 128'(0));
        chk("midrst_rready", 128'(rready), 128'(0));
        chk("midrst_txn_done", 128'(txn_done), 128'(0));
        chk("midrst_error", 128'(error), 128'(0));
        areset = 0;
        run_scen(7, tbl[0]);

        // write address never accepted
        aw_block = 1; clear_obs();
        @(negedge clk); init = 1;
        @(negedge clk); init = 0;
        n = 0;
        while (!awvalid && n < 100) begin @(negedge clk); n++; end
        chk("stuck_aw_rise", 128'(awvalid), 128'(1));
`ifdef AXI_PATTERN_TIMEOUT_EN
        repeat (1023) @(negedge clk);
        chk("wd_aw_still_high", 128'(awvalid), 128'(1));
        @(negedge clk);
        chk("wd_aw_dropped", 128'(awvalid), 128'(0));
        chk("wd_txn_done", 128'(txn_done), 128'(1));
        chk("wd_error", 128'(error), 128'(1));
`else
        repeat (5000) @(negedge clk);
        chk("stuck_aw_high", 128'(awvalid), 128'(1));
        chk("stuck_no_done", 128'(txn_done), 128'(0));
`endif
        pulse_reset();
        aw_block = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
